routing_checker_usp_mp: RTL and testbench
=========================================

# routing_checker_usp_mp

Registered, multi-port successor to the USP CQ routing checker for the CPM5 USP / PL-PCIe5 DSP switch. Sits on the USP completer-request (CQ) AXI4-Stream path, between the CPM5 CQ master and the downstream-port forwarding logic. It decodes each request descriptor once, on the first beat, and attaches a per-packet route to all beats. Unroutable requests are flagged as unsupported (UR) and counted, and can optionally be dropped.

## Interface
- USP_IF_WIDTH, 512, CQ tdata width (descriptor in beat 0, bits [127:0])
- USP_CQ_TUSER_WIDTH, 232, CQ tuser width
- USP_TKEEP_WIDTH, 16, CQ tkeep width
- NUM_DSP, 2, downstream ports (1..8)
- MEM_FWD, 1, 1 = memory requests routed by BAR ID; 0 = memory requests are UR
- Port indices are PW = max(1, $clog2(NUM_DSP)) bits wide.
- Clock and reset: one clock; reset is synchronous and active-high.

Ports (name, direction, width, meaning):
- user_clk  in  1  clock
- user_reset  in  1  synchronous, active-high reset
- dsp_sec_bus  in  8*NUM_DSP  secondary bus per DSP; port i at [8i+7:8i]
- dsp_sub_bus  in  8*NUM_DSP  subordinate bus per DSP
- all_bus_numbers_ready  in  1  bus numbers enumerated and valid
- m_axis_cq_tdata/tkeep/tlast/tuser/tvalid  in  per parameters  CQ input
- m_axis_cq_tready  out  1  CQ input ready (registered)
- m_axis_cq_tdata_new/tkeep_new/tlast_new/tuser_new/tvalid_new  out  per parameters  registered CQ output
- m_axis_cq_tready_new  in  1  downstream ready
- route_port  out  PW  destination DSP; valid with tvalid_new
- route_cfg_type0  out  1  packet targets device 0 on the DSP secondary bus, so the forwarder must convert Type 1 to Type 0
- unsupported_req  out  1  packet is UR; valid with tvalid_new
- ur_info  out  24  {req_type[3:0], tag[7:0], requester_id[11:0]} of the last UR; holds its value until the next UR
- ur_info_valid  out  1  one-cycle pulse when ur_info updates
- ur_count  out  16  saturating UR packet count

## Operation
- Descriptor fields, decoded on the SOP beat only:
  - req_type = tdata[78:75]
  - bus = tdata[119:112]
  - devfn = tdata[111:104]
  - bar_id = tdata[114:112]
  - requester_id = tdata[95:80]; ur_info uses bits [91:80]
  - tag = tdata[103:96]
- Route decision, in priority order. For a range check, the lowest matching DSP index wins.
  1. all_bus_numbers_ready = 0 → UR.
  2. Cfg Type 1 (4'b1010 or 4'b1011), bus == sec[i] and devfn[7:3] == 0 → route i, cfg_type0 = 1.
  3. Cfg Type 1, sec[i] < bus <= sub[i] → route i, cfg_type0 = 0.
  4. Mem read or write (4'b0000 or 4'b0001), MEM_FWD = 1, bar_id < NUM_DSP → route bar_id.
  5. Anything else, including Cfg Type 0 and all other types → UR.
- For UR packets, route_port = 0 and route_cfg_type0 = 0.
- Packet FSM:
  - IDLE: an accepted beat goes to FWD, or to DROP when the packet is UR in drop mode. An accepted beat with tlast stays in IDLE.
  - FWD: beats reuse the latched route. An accepted tlast beat returns to IDLE.
  - DROP: beats are accepted and not forwarded. An accepted tlast beat returns to IDLE.
- UR bookkeeping happens once per UR packet, at SOP acceptance:
  - ur_count increments and saturates at 16'hFFFF.
  - ur_info is captured and ur_info_valid pulses.
- all_bus_numbers_ready and the bus inputs are sampled at SOP only. A change mid-packet does not alter the latched route.

## Timing
- Two-entry skid buffer; full throughput of 1 beat per cycle.
- Latency from input accept to tvalid_new is 1 cycle.
- m_axis_cq_tready is driven from a register. It deasserts only when both skid entries are full.
- While tvalid_new = 1 and tready_new = 0, the output payload, route_port, route_cfg_type0 and unsupported_req hold stable.
- In DROP, m_axis_cq_tready = 1 regardless of tready_new. No output beat is produced.
- Reset values:
  - tvalid_new = 0, m_axis_cq_tready = 0 (goes to 1 in the first cycle after reset deasserts)
  - FSM = IDLE, ur_count = 0, ur_info = 0, ur_info_valid = 0
  - route_port = 0, route_cfg_type0 = 0, unsupported_req = 0
  - tdata_new, tkeep_new, tuser_new, tlast_new = 0
- Reset mid-packet discards the partial packet and buffered beats. The first post-reset beat is treated as SOP.
- A UR count event and saturation in the same cycle leave ur_count at 16'hFFFF.

## Configuration
- Macro: ROUTING_CHECKER_UR_DROP_EN.
- Defined:
  - UR packets are consumed and dropped via the DROP state.
  - unsupported_req is never asserted on the output stream.
  - ur_info, ur_info_valid and ur_count still report every UR.
- Not defined:
  - UR packets are forwarded intact through FWD, with unsupported_req = 1 on every beat and route_port = 0.
  - The DROP state is not built.

## Test plan
- NUM_DSP = 2, sec = {8'h05, 8'h02}, sub = {8'h07, 8'h04}, ready = 1. Cfg Type 1 read, bus 8'h02, devfn 8'h00 → route_port 0, cfg_type0 1, unsupported_req 0, after 1 cycle.
- Same configuration, Cfg Type 1 write to bus 8'h06 → route_port 1, cfg_type0 0. Then bus 8'h09 → UR, ur_count 1, ur_info holds that packet's tag and requester ID.
- Memory write, bar_id 1, 4 beats, tready_new toggling 1/0 → all 4 beats delivered in order, route 1 on every beat, output held stable while stalled.
- all_bus_numbers_ready = 0, valid Cfg Type 1 → UR.
  - With ROUTING_CHECKER_UR_DROP_EN: no output beat, m_axis_cq_tready stays 1 for all input beats.
  - Without: the packet is forwarded with unsupported_req = 1.
- Force ur_count to 16'hFFFE and send 3 UR packets → ur_count 16'hFFFF and holds. Then assert user_reset mid-packet → ur_count 0, tvalid_new 0, and the next beat is decoded as SOP.

Source files
------------

// File: rtl/routing_checker_usp_mp.sv
// -----------------------------------------------------------------------------
// routing_checker_usp_mp
//
// Registered, multi-port routing checker for the USP completer-request (CQ)
// AXI4-Stream path of the CPM5 USP / PL-PCIe5 DSP switch. The request
// descriptor is decoded once, on the first beat (SOP) of each packet, and the
// resulting route is latched and attached to every beat of that packet.
// Unroutable requests are flagged as unsupported (UR), recorded in ur_info,
// counted in a saturating ur_count and, optionally, dropped.
//
// Build option:
//   ROUTING_CHECKER_UR_DROP_EN  defined   : UR packets are consumed through the
//                                           DROP state and never reach the
//                                           output stream.
//                               undefined : UR packets are forwarded intact
//                                           with unsupported_req = 1.
//
// Ports:
//   user_clk, user_reset          clock, synchronous active-high reset
//   dsp_sec_bus / dsp_sub_bus     secondary / subordinate bus per DSP,
//                                 port i at [8i+7:8i]
//   all_bus_numbers_ready         bus numbers valid (sampled at SOP only)
//   m_axis_cq_*                   CQ input stream (tready is registered)
//   m_axis_cq_*_new               registered CQ output stream
//   route_port                    destination DSP, valid with tvalid_new
//   route_cfg_type0               forwarder must convert Cfg Type 1 to Type 0
//   unsupported_req               packet is UR, valid with tvalid_new
//   ur_info                       {req_type, tag, requester_id[11:0]} of last UR
//   ur_info_valid                 one-cycle pulse when ur_info updates
//   ur_count                      saturating UR packet count
// -----------------------------------------------------------------------------
module routing_checker_usp_mp #(
  parameter int USP_IF_WIDTH       = 512,
  parameter int USP_CQ_TUSER_WIDTH = 232,
  parameter int USP_TKEEP_WIDTH    = 16,
  parameter int NUM_DSP            = 2,
  parameter int MEM_FWD            = 1,
  localparam int PW                = (NUM_DSP > 1) ? $clog2(NUM_DSP) : 1
) (
  input  logic                          user_clk,
  input  logic                          user_reset,
  input  logic [8*NUM_DSP-1:0]          dsp_sec_bus,
  input  logic [8*NUM_DSP-1:0]          dsp_sub_bus,
  input  logic                          all_bus_numbers_ready,
  input  logic [USP_IF_WIDTH-1:0]       m_axis_cq_tdata,
  input  logic [USP_TKEEP_WIDTH-1:0]    m_axis_cq_tkeep,
  input  logic                          m_axis_cq_tlast,
  input  logic [USP_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser,
  input  logic                          m_axis_cq_tvalid,
  output logic                          m_axis_cq_tready,
  output logic [USP_IF_WIDTH-1:0]       m_axis_cq_tdata_new,
  output logic [USP_TKEEP_WIDTH-1:0]    m_axis_cq_tkeep_new,
  output logic                          m_axis_cq_tlast_new,
  output logic [USP_CQ_TUSER_WIDTH-1:0] m_axis_cq_tuser_new,
  output logic                          m_axis_cq_tvalid_new,
  input  logic                          m_axis_cq_tready_new,
  output logic [PW-1:0]                 route_port,
  output logic                          route_cfg_type0,
  output logic                          unsupported_req,
  output logic [23:0]                   ur_info,
  output logic                          ur_info_valid,
  output logic [15:0]                   ur_count
);

  localparam logic [3:0] NUM_DSP_L = 4'(NUM_DSP);

  // One buffered beat: payload plus the route attached to it.
  typedef struct packed {
    logic [USP_IF_WIDTH-1:0]       tdata;
    logic [USP_TKEEP_WIDTH-1:0]    tkeep;
    logic                          tlast;
    logic [USP_CQ_TUSER_WIDTH-1:0] tuser;
    logic [PW-1:0]                 port;
    logic                          cfg0;
    logic                          ur;
  } beat_t;

`ifdef ROUTING_CHECKER_UR_DROP_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1, ST_DROP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FWD = 2'd1} state_t;
`endif

  // ---------------------------------------------------------------------------
  // Descriptor decode (meaningful on the SOP beat only)
  // ---------------------------------------------------------------------------
  logic [3:0]  dec_req_type;
  logic [7:0]  dec_bus;
  logic [4:0]  dec_dev;
  logic [2:0]  dec_bar_id;
  logic [11:0] dec_rid;
  logic [7:0]  dec_tag;
  logic        is_cfg1;
  logic        is_mem;

  assign dec_req_type = m_axis_cq_tdata[78:75];
  assign dec_bus      = m_axis_cq_tdata[119:112];
  assign dec_dev      = m_axis_cq_tdata[111:107];
  assign dec_bar_id   = m_axis_cq_tdata[114:112];
  assign dec_rid      = m_axis_cq_tdata[91:80];
  assign dec_tag      = m_axis_cq_tdata[103:96];

  assign is_cfg1 = (dec_req_type == 4'b1010) || (dec_req_type == 4'b1011);
  assign is_mem  = (dec_req_type == 4'b0000) || (dec_req_type == 4'b0001);

  logic [NUM_DSP-1:0] t0_hit;
  logic [NUM_DSP-1:0] range_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DSP; gi++) begin : g_dsp
      logic [7:0] sec;
      logic [7:0] sub;
      assign sec = dsp_sec_bus[8*gi +: 8];
      assign sub = dsp_sub_bus[8*gi +: 8];
      // Device 0 on the secondary bus itself: Type 1 must become Type 0.
      assign t0_hit[gi]    = is_cfg1 && (dec_bus == sec) && (dec_dev == 5'd0);
      // Bus behind this DSP's secondary bus: pass Type 1 through.
      assign range_hit[gi] = is_cfg1 && (dec_bus > sec) && (dec_bus <= sub);
    end
  endgenerate

  logic [PW-1:0] t0_idx;
  logic [PW-1:0] range_idx;
  logic [PW-1:0] dec_port;
  logic          dec_cfg0;
  logic          dec_ur;

  always_comb begin
    t0_idx    = '0;
    range_idx = '0;
    // Scan downwards so the lowest matching index is the one left standing.
    for (int i = NUM_DSP - 1; i >= 0; i--) begin
      if (t0_hit[i])    t0_idx    = PW'(i);
      if (range_hit[i]) range_idx = PW'(i);
    end

    dec_port = '0;
    dec_cfg0 = 1'b0;
    dec_ur   = 1'b1;
    if (!all_bus_numbers_ready) begin
      dec_ur = 1'b1;
    end else if (|t0_hit) begin
      dec_port = t0_idx;
      dec_cfg0 = 1'b1;
      dec_ur   = 1'b0;
    end else if (|range_hit) begin
      dec_port = range_idx;
      dec_ur   = 1'b0;
    end else if (is_mem && (MEM_FWD != 0) && ({1'b0, dec_bar_id} < NUM_DSP_L)) begin
      dec_port = PW'(dec_bar_id);
      dec_ur   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t        state_reg, state_next;
  logic [1:0]    count_reg, count_next;
  beat_t         head_reg, head_next;
  beat_t         skid_reg, skid_next;
  logic          out_valid_reg, out_valid_next;
  logic          tready_reg, tready_next;
  logic [PW-1:0] lat_port_reg;
  logic          lat_cfg0_reg;
  logic          lat_ur_reg;
  logic [15:0]   ur_count_reg, ur_count_next;
  logic [23:0]   ur_info_reg;
  logic          ur_info_valid_reg;

  logic  accept;
  logic  sop;
  logic  drop_beat;
  logic  push;
  logic  pop;
  logic  ur_event;
  beat_t in_beat;

  assign accept   = m_axis_cq_tvalid && tready_reg;
  assign pop      = out_valid_reg && m_axis_cq_tready_new;
  assign ur_event = accept && sop && dec_ur;

  // ---------------------------------------------------------------------------
  // Packet FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Packet FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && !m_axis_cq_tlast) begin
`ifdef ROUTING_CHECKER_UR_DROP_EN
          state_next = dec_ur ? ST_DROP : ST_FWD;
`else
          state_next = ST_FWD;
`endif
        end
      end
      default: begin
        if (accept && m_axis_cq_tlast) state_next = ST_IDLE;
      end
    endcase
  end

  // Packet FSM: outputs (SOP flag and whether the accepted beat is discarded)
  always_comb begin
    sop       = (state_reg == ST_IDLE);
    drop_beat = 1'b0;
`ifdef ROUTING_CHECKER_UR_DROP_EN
    drop_beat = accept && ((sop && dec_ur) || (state_reg == ST_DROP));
`endif
    push      = accept && !drop_beat;
  end

  // Beat to enqueue: SOP uses the fresh decode, later beats the latched route.
  always_comb begin
    in_beat.tdata = m_axis_cq_tdata;
    in_beat.tkeep = m_axis_cq_tkeep;
    in_beat.tlast = m_axis_cq_tlast;
    in_beat.tuser = m_axis_cq_tuser;
    in_beat.port  = sop ? dec_port : lat_port_reg;
    in_beat.cfg0  = sop ? dec_cfg0 : lat_cfg0_reg;
    in_beat.ur    = sop ? dec_ur   : lat_ur_reg;
  end

  // ---------------------------------------------------------------------------
  // Two-entry skid buffer: head_reg drives the output, skid_reg catches the
  // beat that was already in flight when the downstream stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    case (count_reg)
      2'd0: begin
        if (push) begin
          head_next  = in_beat;
          count_next = 2'd1;
        end
      end
      2'd1: begin
        if (pop && push) begin
          head_next = in_beat;
        end else if (pop) begin
          count_next = 2'd0;
        end else if (push) begin
          skid_next  = in_beat;
          count_next = 2'd2;
        end
      end
      default: begin
        // Input is not ready with both entries full, so no push here.
        if (pop) begin
          head_next  = skid_reg;
          count_next = 2'd1;
        end
      end
    endcase
    out_valid_next = (count_next != 2'd0);
`ifdef ROUTING_CHECKER_UR_DROP_EN
    // Dropped beats never occupy the buffer, so DROP can always accept.
    tready_next = (count_next != 2'd2) || (state_next == ST_DROP);
`else
    tready_next = (count_next != 2'd2);
`endif
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      count_reg     <= 2'd0;
      head_reg      <= '0;
      skid_reg      <= '0;
      out_valid_reg <= 1'b0;
      tready_reg    <= 1'b0;
    end else begin
      count_reg     <= count_next;
      head_reg      <= head_next;
      skid_reg      <= skid_next;
      out_valid_reg <= out_valid_next;
      tready_reg    <= tready_next;
    end
  end

  // Route latched at SOP acceptance for the remaining beats of the packet.
  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      lat_port_reg <= '0;
      lat_cfg0_reg <= 1'b0;
      lat_ur_reg   <= 1'b0;
    end else if (accept && sop) begin
      lat_port_reg <= dec_port;
      lat_cfg0_reg <= dec_cfg0;
      lat_ur_reg   <= dec_ur;
    end
  end

  // ---------------------------------------------------------------------------
  // UR bookkeeping, once per UR packet
  // ---------------------------------------------------------------------------
  always_comb begin
    ur_count_next = ur_count_reg;
    if (ur_event && (ur_count_reg != 16'hFFFF)) ur_count_next = ur_count_reg + 16'd1;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      ur_count_reg      <= 16'd0;
      ur_info_reg       <= 24'd0;
      ur_info_valid_reg <= 1'b0;
    end else begin
      ur_count_reg      <= ur_count_next;
      ur_info_valid_reg <= ur_event;
      if (ur_event) ur_info_reg <= {dec_req_type, dec_tag, dec_rid};
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign m_axis_cq_tready     = tready_reg;
  assign m_axis_cq_tvalid_new = out_valid_reg;
  assign m_axis_cq_tdata_new  = head_reg.tdata;
  assign m_axis_cq_tkeep_new  = head_reg.tkeep;
  assign m_axis_cq_tlast_new  = head_reg.tlast;
  assign m_axis_cq_tuser_new  = head_reg.tuser;
  assign route_port           = head_reg.port;
  assign route_cfg_type0      = head_reg.cfg0;
  assign unsupported_req      = head_reg.ur;
  assign ur_info              = ur_info_reg;
  assign ur_info_valid        = ur_info_valid_reg;
  assign ur_count             = ur_count_reg;

endmodule

// File: tb/tb_routing_checker_usp_mp.sv
// -----------------------------------------------------------------------------
// tb_routing_checker_usp_mp
//
// Directed bench for routing_checker_usp_mp with NUM_DSP = 2,
// sec = {8'h05, 8'h02}, sub = {8'h07, 8'h04}. Works for both builds of
// ROUTING_CHECKER_UR_DROP_EN.
// -----------------------------------------------------------------------------
module tb_routing_checker_usp_mp;

  localparam int DW = 512;
  localparam int UW = 232;
  localparam int KW = 16;

  logic          clk = 1'b0;
  logic          user_reset;
  logic [15:0]   dsp_sec_bus;
  logic [15:0]   dsp_sub_bus;
  logic          all_bus_numbers_ready;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata_new;
  logic [KW-1:0] tkeep_new;
  logic          tlast_new;
  logic [UW-1:0] tuser_new;
  logic          tvalid_new;
  logic          tready_new;
  logic [0:0]    route_port;
  logic          route_cfg_type0;
  logic          unsupported_req;
  logic [23:0]   ur_info;
  logic          ur_info_valid;
  logic [15:0]   ur_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  routing_checker_usp_mp #(
    .USP_IF_WIDTH(DW), .USP_CQ_TUSER_WIDTH(UW), .USP_TKEEP_WIDTH(KW),
    .NUM_DSP(2), .MEM_FWD(1)
  ) dut (
    .user_clk(clk), .user_reset(user_reset),
    .dsp_sec_bus(dsp_sec_bus), .dsp_sub_bus(dsp_sub_bus),
    .all_bus_numbers_ready(all_bus_numbers_ready),
    .m_axis_cq_tdata(tdata), .m_axis_cq_tkeep(tkeep), .m_axis_cq_tlast(tlast),
    .m_axis_cq_tuser(tuser), .m_axis_cq_tvalid(tvalid), .m_axis_cq_tready(tready),
    .m_axis_cq_tdata_new(tdata_new), .m_axis_cq_tkeep_new(tkeep_new),
    .m_axis_cq_tlast_new(tlast_new), .m_axis_cq_tuser_new(tuser_new),
    .m_axis_cq_tvalid_new(tvalid_new), .m_axis_cq_tready_new(tready_new),
    .route_port(route_port), .route_cfg_type0(route_cfg_type0),
    .unsupported_req(unsupported_req), .ur_info(ur_info),
    .ur_info_valid(ur_info_valid), .ur_count(ur_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] make_desc(input logic [3:0] t, input logic [7:0] bus,
                                             input logic [7:0] devfn, input logic [7:0] tag,
                                             input logic [15:0] rid);
    logic [511:0] d;
    d = '0;
    d[511:128] = {12{32'hF00D_1234}};
    d[78:75]   = t;
    d[95:80]   = rid;
    d[103:96]  = tag;
    d[111:104] = devfn;
    d[119:112] = bus;
    return d;
  endfunction

  // Present one beat, wait (bounded) for acceptance, then withdraw tvalid.
  // Returns at posedge+1 after the accepting edge.
  task automatic drive(input logic [511:0] d, input logic last);
    int n;
    tdata  = d;
    tlast  = last;
    tkeep  = '1;
    tuser  = UW'(d[127:0]);
    tvalid = 1'b1;
    n = 0;
    while (!tready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) chk("accept_timeout", 1, 0);
    tick();
    tvalid = 1'b0;
    $display("tx type=%b bus=%h last=%0d -> tvalid_new=%0d port=%0d cfg0=%0d ur=%0d ur_count=%0d",
             d[78:75], d[119:112], last, tvalid_new, route_port, route_cfg_type0,
             unsupported_req, ur_count);
  endtask

  logic [511:0] mw [4];
  logic [511:0] prev_data;
  logic [0:0]   prev_port;
  logic         stalled_prev;
  logic         in_fire;
  int           in_k;
  int           out_k;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset            = 1'b1;
    dsp_sec_bus           = {8'h05, 8'h02};
    dsp_sub_bus           = {8'h07, 8'h04};
    all_bus_numbers_ready = 1'b1;
    tdata                 = '0;
    tkeep                 = '0;
    tlast                 = 1'b0;
    tuser                 = '0;
    tvalid                = 1'b0;
    tready_new            = 1'b1;

    // Reset state
    tick(); tick(); tick();
    chk("rst_tvalid_new", tvalid_new, 0);
    chk("rst_tready", tready, 0);
    chk("rst_ur_count", ur_count, 0);
    chk("rst_ur_info", ur_info, 0);
    chk("rst_ur_info_valid", ur_info_valid, 0);
    chk("rst_route", {route_port, route_cfg_type0, unsupported_req}, 0);
    chk("rst_tdata_new", tdata_new, 0);
    chk("rst_tlast_tkeep_tuser", {tlast_new, tkeep_new, tuser_new}, 0);
    user_reset = 1'b0;
    chk("tready_before_first_cycle", tready, 0);
    tick();
    chk("tready_after_reset", tready, 1);

    // Cfg Type 1 read to device 0 on DSP0's secondary bus
    chk("pre_t0_tvalid_new", tvalid_new, 0);
    drive(make_desc(4'b1010, 8'h02, 8'h00, 8'h11, 16'h0123), 1'b1);
    chk("t0_tvalid_new", tvalid_new, 1);
    chk("t0_port", route_port, 0);
    chk("t0_cfg0", route_cfg_type0, 1);
    chk("t0_ur", unsupported_req, 0);
    chk("t0_tdata", tdata_new, make_desc(4'b1010, 8'h02, 8'h00, 8'h11, 16'h0123));
    tick();
    chk("t0_drained", tvalid_new, 0);

    // Cfg Type 1 write to bus 06 (behind DSP1)
    drive(make_desc(4'b1011, 8'h06, 8'h08, 8'h22, 16'h0456), 1'b1);
    chk("rng_tvalid_new", tvalid_new, 1);
    chk("rng_port", route_port, 1);
    chk("rng_cfg0", route_cfg_type0, 0);
    chk("rng_ur", unsupported_req, 0);
    tick();

    // Cfg Type 1 write to bus 09: no DSP claims it
    drive(make_desc(4'b1011, 8'h09, 8'h00, 8'h33, 16'hA789), 1'b1);
    chk("ur1_count", ur_count, 1);
    chk("ur1_info", ur_info, 24'hB33789);
    chk("ur1_info_valid", ur_info_valid, 1);
`ifdef ROUTING_CHECKER_UR_DROP_EN
    chk("ur1_dropped", tvalid_new, 0);
`else
    chk("ur1_fwd_tvalid", tvalid_new, 1);
    chk("ur1_fwd_flags", {route_port, route_cfg_type0, unsupported_req}, 3'b001);
`endif
    tick();
    chk("ur1_info_valid_pulse", ur_info_valid, 0);
    chk("ur1_info_hold", ur_info, 24'hB33789);

    // 4-beat memory write to BAR 1, downstream ready toggling
    mw[0] = make_desc(4'b0001, 8'h01, 8'h00, 8'h44, 16'h0001);
    mw[1] = {16{32'hC0DE_0001}};
    mw[2] = {16{32'hC0DE_0002}};
    mw[3] = {16{32'hC0DE_0003}};
    in_k = 0;
    out_k = 0;
    stalled_prev = 1'b0;
    prev_data = '0;
    prev_port = '0;
    for (int cyc = 0; cyc < 40 && out_k < 4; cyc++) begin
      tready_new = (cyc % 2 == 0);
      if (in_k < 4) begin
        tvalid = 1'b1;
        tdata  = mw[in_k];
        tlast  = (in_k == 3);
        tkeep  = '1;
        tuser  = UW'(in_k + 1);
      end else begin
        tvalid = 1'b0;
      end
      if (stalled_prev) begin
        chk("mw_hold_valid", tvalid_new, 1);
        chk("mw_hold_data", tdata_new, prev_data);
        chk("mw_hold_port", route_port, prev_port);
      end
      if (tvalid_new && tready_new) begin
        chk("mw_data", tdata_new, mw[out_k]);
        chk("mw_port", route_port, 1);
        chk("mw_ur_cfg0", {route_cfg_type0, unsupported_req}, 0);
        chk("mw_tlast", tlast_new, (out_k == 3));
        chk("mw_tuser", tuser_new, out_k + 1);
        $display("tx mw beat=%0d port=%0d", out_k, route_port);
        out_k++;
      end
      stalled_prev = tvalid_new && !tready_new;
      prev_data    = tdata_new;
      prev_port    = route_port;
      in_fire      = tvalid && tready;
      tick();
      if (in_fire) in_k++;
    end
    tvalid = 1'b0;
    tready_new = 1'b1;
    chk("mw_beats_out", out_k, 4);
    tick();

    // Bus numbers not ready at SOP; becomes ready mid-packet (must not matter)
    all_bus_numbers_ready = 1'b0;
    tdata  = make_desc(4'b1010, 8'h02, 8'h00, 8'h55, 16'h0ABC);
    tlast  = 1'b0;
    tvalid = 1'b1;
    chk("nr_tready_b0", tready, 1);
    tick();
    all_bus_numbers_ready = 1'b1;
    tdata = {16{32'h5A5A_5A5A}};
    tlast = 1'b1;
    chk("nr_tready_b1", tready, 1);
`ifdef ROUTING_CHECKER_UR_DROP_EN
    chk("nr_no_out_b0", tvalid_new, 0);
`else
    chk("nr_b0_tvalid", tvalid_new, 1);
    chk("nr_b0_flags", {route_port, route_cfg_type0, unsupported_req}, 3'b001);
`endif
    tick();
    tvalid = 1'b0;
`ifdef ROUTING_CHECKER_UR_DROP_EN
    chk("nr_no_out_b1", tvalid_new, 0);
    chk("nr_tready_after", tready, 1);
`else
    chk("nr_b1_tvalid", tvalid_new, 1);
    chk("nr_b1_flags", {route_port, route_cfg_type0, unsupported_req}, 3'b001);
    chk("nr_b1_tlast", tlast_new, 1);
`endif
    chk("nr_ur_count", ur_count, 2);
    chk("nr_ur_info", ur_info, 24'hA55ABC);
    tick();
    chk("nr_drained", tvalid_new, 0);

    // Saturation of ur_count
    force dut.ur_count_reg = 16'hFFFE;
    #1;
    release dut.ur_count_reg;
    chk("sat_preload", ur_count, 16'hFFFE);
    drive(make_desc(4'b1000, 8'h02, 8'h00, 8'h61, 16'h0001), 1'b1);
    chk("sat_1", ur_count, 16'hFFFF);
    tick();
    drive(make_desc(4'b1000, 8'h02, 8'h00, 8'h62, 16'h0002), 1'b1);
    chk("sat_2", ur_count, 16'hFFFF);
    chk("sat_2_info_valid", ur_info_valid, 1);
    tick();
    drive(make_desc(4'b1000, 8'h02, 8'h00, 8'h63, 16'h0003), 1'b1);
    chk("sat_3", ur_count, 16'hFFFF);
    chk("sat_3_info", ur_info, 24'h863003);
    tick();

    // Reset in the middle of a memory packet to DSP0
    drive(make_desc(4'b0000, 8'h00, 8'h00, 8'h70, 16'h0007), 1'b0);
    chk("mid_sop_port", route_port, 0);
    user_reset = 1'b1;
    tick();
    chk("mid_rst_ur_count", ur_count, 0);
    chk("mid_rst_tvalid_new", tvalid_new, 0);
    chk("mid_rst_tready", tready, 0);
    user_reset = 1'b0;
    tick();
    drive(make_desc(4'b1011, 8'h06, 8'h00, 8'h71, 16'h0008), 1'b1);
    chk("post_rst_sop_tvalid", tvalid_new, 1);
    chk("post_rst_sop_port", route_port, 1);
    chk("post_rst_sop_flags", {route_cfg_type0, unsupported_req}, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
